btn_debounce_ce: RTL and testbench

BTN_DEBOUNCE_CE -- requirements
Module: btn_debounce_ce

---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_debounce_ch.sv | 111 +++++++++++
 rtl/btn_debounce_ce.sv | 82 ++++++++
 tb/tb_btn_debounce_ce.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button debouncer: channel FSM states and timing constants.
package btn_pkg;

  localparam int F_CLK_DEFAULT = 50_000_000;
  localparam int DIV_1MS       = F_CLK_DEFAULT / 1000;
  localparam int DIV_10        = 10;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CONF_HI = 2'd1,
    IDLE_HI = 2'd2,
    CONF_LO = 2'd3
  } btn_state_t;

  // Clock cycles per millisecond for an arbitrary build frequency.
  function automatic int div_1ms(input int f_clk);
    return f_clk / 1000;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, confirm FSM and stable counter.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int STABLE_MS = 8
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_raw,
  input  logic i_ce,
  output logic o_level
);

  localparam logic [7:0] L_TARGET = 8'(STABLE_MS);

  logic       r_sync_meta;
  logic       r_sync;
  btn_state_t r_state;
  btn_state_t w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_cnt_inc;
  logic       r_level;
  logic       w_level_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_meta <= 1'b0;
      r_sync      <= 1'b0;
    end else begin
      r_sync_meta <= i_raw;
      r_sync      <= r_sync_meta;
    end
  end

  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    // NOTE: hold-by-default on every output of this block keeps it free of inferred latches.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    if (i_ce) begin
      case (r_state)
        IDLE_LO: if (r_sync) begin
          if (STABLE_MS == 1) begin
            w_state_nxt = IDLE_HI;
            w_level_nxt = 1'b1;
          end else begin
            w_state_nxt = CONF_HI;
            w_cnt_nxt   = 8'd1;
          end
        end
        CONF_HI: if (r_sync) begin
          if (w_cnt_inc == L_TARGET) begin
            w_state_nxt = IDLE_HI;
            w_level_nxt = 1'b1;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_state_nxt = IDLE_LO;
          w_cnt_nxt   = 8'd0;
        end
        IDLE_HI: if (!r_sync) begin
          if (STABLE_MS == 1) begin
            w_state_nxt = IDLE_LO;
            w_level_nxt = 1'b0;
          end else begin
            w_state_nxt = CONF_LO;
            w_cnt_nxt   = 8'd1;
          end
        end
        CONF_LO: if (!r_sync) begin
          if (w_cnt_inc == L_TARGET) begin
            w_state_nxt = IDLE_LO;
            w_level_nxt = 1'b0;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_state_nxt = IDLE_HI;
          w_cnt_nxt   = 8'd0;
        end
        default: begin
          w_state_nxt = IDLE_LO;
          w_cnt_nxt   = 8'd0;
          w_level_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE_LO;
      r_cnt   <= 8'd0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/btn_debounce_ce.sv
// Two-button debouncer with shared 1 ms / 10 ms clock-enable strobes.
module btn_debounce_ce
  import btn_pkg::*;
#(
  parameter int F_CLK     = 50_000_000,
  parameter int STABLE_MS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic BTN_UP_RAW,
  input  logic BTN_DOWN_RAW,
  output logic BTN_UP,
  output logic BTN_DOWN,
  output logic ce1ms,
  output logic ce10ms
);

  localparam int L_DIV = div_1ms(F_CLK);
  localparam int L_PW  = (L_DIV > 1) ? $clog2(L_DIV) : 1;

  logic            r_rst_meta;
  logic            r_rst_sync;
  logic            w_rst_n;
  logic [L_PW-1:0] r_pre;
  logic            w_pre_last;
  logic [3:0]      r_dec;
  logic            w_dec_last;

  // Reset asserts asynchronously but releases two clocks later, aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  assign w_pre_last = (r_pre == L_PW'(L_DIV - 1));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pre <= '0;
    end else if (w_pre_last) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + L_PW'(1);
    end
  end

  assign ce1ms      = w_pre_last & w_rst_n;
  assign w_dec_last = (r_dec == 4'(DIV_10 - 1));
  assign ce10ms     = ce1ms & w_dec_last;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dec <= 4'd0;
    end else if (ce1ms) begin
      r_dec <= w_dec_last ? 4'd0 : r_dec + 4'd1;
    end
  end

  btn_debounce_ch #(.STABLE_MS(STABLE_MS)) u_ch_up (
    .clk     (clk),
    .i_rst_n (w_rst_n),
    .i_raw   (BTN_UP_RAW),
    .i_ce    (ce1ms),
    .o_level (BTN_UP)
  );

  btn_debounce_ch #(.STABLE_MS(STABLE_MS)) u_ch_down (
    .clk     (clk),
    .i_rst_n (w_rst_n),
    .i_raw   (BTN_DOWN_RAW),
    .i_ce    (ce1ms),
    .o_level (BTN_DOWN)
  );

endmodule

// File: tb/tb_btn_debounce_ce.sv
// Bench for btn_debounce_ce: 10 clk per ms, STABLE_MS=4 main instance plus a STABLE_MS=1 instance.
module tb_btn_debounce_ce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic up_raw = 1'b0, down_raw = 1'b0;
  logic up1_raw = 1'b0, down1_raw = 1'b0;
  logic up, down, ce1, ce10;
  logic up1, down1, ce1_1, ce10_1;

  typedef struct {
    int   cyc;
    int   ch;
    logic val;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  logic prev[3];

  always #5 clk = ~clk;

  btn_debounce_ce #(.F_CLK(10_000), .STABLE_MS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .BTN_UP_RAW   (up_raw),
    .BTN_DOWN_RAW (down_raw),
    .BTN_UP       (up),
    .BTN_DOWN     (down),
    .ce1ms        (ce1),
    .ce10ms       (ce10)
  );

  btn_debounce_ce #(.F_CLK(10_000), .STABLE_MS(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .BTN_UP_RAW   (up1_raw),
    .BTN_DOWN_RAW (down1_raw),
    .BTN_UP       (up1),
    .BTN_DOWN     (down1),
    .ce1ms        (ce1_1),
    .ce10ms       (ce10_1)
  );

  // Cycle numbering: cycle n has prescaler count n-1, so strobes fall on multiples of 10.
  function automatic int nth_strobe(input int from, input int n);
    int s;
    s = ((from + 9) / 10) * 10;
    return s + (n - 1) * 10;
  endfunction

  function automatic logic obs(input int ch);
    case (ch)
      0:       return up;
      1:       return down;
      default: return up1;
    endcase
  endfunction

  task automatic push(input int ch, input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.ch  = ch;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      for (int ch = 0; ch < 3; ch++) begin
        logic v;
        ev_t  e;
        v = obs(ch);
        if (v !== prev[ch]) begin
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: ch%0d went %b at cyc %0d, required no change", ch, v, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.ch == ch && e.cyc == cyc && e.val === v) n_pass++;
            else $display("FAIL sb_event: got ch%0d=%b at cyc %0d, required ch%0d=%b at cyc %0d",
                          ch, v, cyc, e.ch, e.val, e.cyc);
          end
          prev[ch] = v;
        end
      end
    end
  endtask

  task automatic drain(input string name);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s: %0d expected output changes never seen, required 0", name, exp_q.size());
    exp_q.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    cyc = 0;
    for (int ch = 0; ch < 3; ch++) prev[ch] = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    up_raw = 1'b1;
    repeat (4) @(negedge clk);
    got = {up, down, ce1, ce10, up1, ce1_1};
    n_total++;
    if (got !== 6'b0) $display("FAIL reset_outputs: got %b, required 000000", got);
    else n_pass++;
    up_raw = 1'b0;
    release_reset();
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 200; i++) begin
      run_cycles(1);
      n_total++;
      if (ce1 !== (cyc % 10 == 0)) $display("FAIL ce1ms cyc %0d: got %b, required %b", cyc, ce1, cyc % 10 == 0);
      else n_pass++;
      n_total++;
      if (ce10 !== (cyc % 100 == 0)) $display("FAIL ce10ms cyc %0d: got %b, required %b", cyc, ce10, cyc % 100 == 0);
      else n_pass++;
      n_total++;
      if (ce1_1 !== (cyc % 10 == 0)) $display("FAIL ce1ms_s1 cyc %0d: got %b, required %b", cyc, ce1_1, cyc % 10 == 0);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    up_raw = 1'b1;
    push(0, nth_strobe(cyc + 2, 4) + 1, 1'b1);
    run_cycles(60);
    drain("clean_rise");
    n_total++;
    if (down !== 1'b0) $display("FAIL clean_down_idle: got %b, required 0", down);
    else n_pass++;
    up_raw = 1'b0;
    push(0, nth_strobe(cyc + 2, 4) + 1, 1'b0);
    run_cycles(60);
    drain("clean_fall");
  endtask

  task automatic test_bounce();
    up_raw = 1'b1;
    run_cycles(20);
    up_raw = 1'b0;
    run_cycles(20);
    up_raw = 1'b1;
    push(0, nth_strobe(cyc + 2, 4) + 1, 1'b1);
    run_cycles(60);
    drain("bounce_rise");
    up_raw = 1'b0;
    push(0, nth_strobe(cyc + 2, 4) + 1, 1'b0);
    run_cycles(60);
    drain("bounce_fall");
  endtask

  task automatic test_glitch();
    while (cyc % 10 != 2) run_cycles(1);
    up_raw = 1'b1;
    run_cycles(3);
    up_raw = 1'b0;
    run_cycles(30);
    n_total++;
    if (up !== 1'b0) $display("FAIL glitch_hidden: got %b, required 0", up);
    else n_pass++;
    drain("glitch_quiet");
  endtask

  task automatic test_simultaneous();
    up_raw   = 1'b1;
    down_raw = 1'b1;
    push(0, nth_strobe(cyc + 2, 4) + 1, 1'b1);
    push(1, nth_strobe(cyc + 2, 4) + 1, 1'b1);
    run_cycles(60);
    drain("simul_rise");
    n_total++;
    if ({up, down} !== 2'b11) $display("FAIL simul_levels: got %b, required 11", {up, down});
    else n_pass++;
    up_raw   = 1'b0;
    down_raw = 1'b0;
    push(0, nth_strobe(cyc + 2, 4) + 1, 1'b0);
    push(1, nth_strobe(cyc + 2, 4) + 1, 1'b0);
    run_cycles(60);
    drain("simul_fall");
  endtask

  task automatic test_reset_mid();
    down_raw = 1'b1;
    push(1, nth_strobe(cyc + 2, 4) + 1, 1'b1);
    run_cycles(60);
    drain("mid_down_rise");
    // Stop right after the third agreeing strobe so the up channel sits in CONF_HI at count 3.
    up_raw = 1'b1;
    run_cycles(nth_strobe(cyc + 2, 3) + 1 - cyc);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({up, down} !== 2'b00) $display("FAIL mid_async_clear: got %b, required 00", {up, down});
    else n_pass++;
    repeat (3) @(negedge clk);
    release_reset();
    push(0, nth_strobe(3, 4) + 1, 1'b1);
    push(1, nth_strobe(3, 4) + 1, 1'b1);
    run_cycles(60);
    drain("mid_full_recount");
    up_raw   = 1'b0;
    down_raw = 1'b0;
    push(0, nth_strobe(cyc + 2, 4) + 1, 1'b0);
    push(1, nth_strobe(cyc + 2, 4) + 1, 1'b0);
    run_cycles(60);
    drain("mid_release");
  endtask

  task automatic test_stable1();
    up1_raw = 1'b1;
    push(2, nth_strobe(cyc + 2, 1) + 1, 1'b1);
    run_cycles(20);
    drain("s1_rise");
    up1_raw = 1'b0;
    push(2, nth_strobe(cyc + 2, 1) + 1, 1'b0);
    run_cycles(20);
    drain("s1_fall");
  endtask

  initial begin
    for (int ch = 0; ch < 3; ch++) prev[ch] = 1'b0;
    test_reset();
    test_free_run();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_stable1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
